bus_mailbox: RTL and testbench

//  Data-bus target (responder) for the core's strobe/mem_rw/d_addr/d_data port.

---
 rtl/bus_mailbox.sv | 200 ++++++++++++++++++++
 tb/tb_bus_mailbox.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mailbox.sv
// bus_mailbox: data-bus responder exposing a 4-word window that bridges the
// core to a TX FIFO (core stores, external consumer pops) and an RX FIFO
// (external producer pushes, core loads), plus status, control and a level
// interrupt. Reads are zero-wait: d_data is driven combinationally from
// registered state during a selected load, and the RX pop lands on the same
// posedge that the core samples the data.
// DEPTH_LOG2 is expected in the range 1..7 so the counts fit their 8-bit
// status fields.
module bus_mailbox #(
    parameter logic [31:0] BASE       = 32'h0000_0100,
    parameter int          DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        strobe,
    input  logic        mem_rw,
    input  logic [31:0] d_addr,
    inout  wire  [31:0] d_data,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [31:0] rx_data,
    output logic        rx_ready,
    output logic        irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PTR_W = DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    // FIFO storage (deliberately not reset)
    logic [31:0]      r_tx_mem [DEPTH];
    logic [31:0]      r_rx_mem [DEPTH];

    logic [PTR_W-1:0] r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
    logic [CNT_W-1:0] r_tx_cnt, r_rx_cnt;
    logic             r_ovf, r_udf;
    logic             r_rx_ie, r_tx_ie;

    logic             w_sel, w_wr, w_rd;
    logic [1:0]       w_off;
    logic             w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic             w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic             w_ovf_evt, w_udf_evt, w_ovf_clr, w_udf_clr;
    logic             w_ctrl_wr;
    logic [31:0]      w_status;
    logic [31:0]      w_rd_data;

    // Address decode: only the top 30 bits of BASE select the window
    assign w_sel = strobe && (d_addr[31:2] == BASE[31:2]);
    assign w_off = d_addr[1:0];
    assign w_wr  = w_sel && mem_rw;
    assign w_rd  = w_sel && !mem_rw;

    // Occupancy flags, all taken from the pre-edge counts
    assign w_tx_full  = (r_tx_cnt == FULL_CNT);
    assign w_tx_empty = (r_tx_cnt == ZERO_CNT);
    assign w_rx_full  = (r_rx_cnt == FULL_CNT);
    assign w_rx_empty = (r_rx_cnt == ZERO_CNT);

    // FIFO events; a store to a full TX is dropped and a load from an empty RX
    // returns zero, each flagging its sticky error instead
    assign w_tx_push = w_wr && (w_off == OFF_DATA) && !w_tx_full;
    assign w_ovf_evt = w_wr && (w_off == OFF_DATA) && w_tx_full;
    assign w_tx_pop  = !w_tx_empty && tx_ready;
    assign w_rx_push = rx_valid && !w_rx_full;
    assign w_rx_pop  = w_rd && (w_off == OFF_DATA) && !w_rx_empty;
    assign w_udf_evt = w_rd && (w_off == OFF_DATA) && w_rx_empty;

    assign w_ovf_clr = w_wr && (w_off == OFF_STATUS) && d_data[4];
    assign w_udf_clr = w_wr && (w_off == OFF_STATUS) && d_data[5];
    assign w_ctrl_wr = w_wr && (w_off == OFF_CTRL);

    // Outputs are pure functions of registered state, so reset reaches them
    // immediately
    assign tx_valid = !w_tx_empty;
    assign tx_data  = r_tx_mem[r_tx_rptr];
    assign rx_ready = !w_rx_full;
    assign irq      = (r_rx_ie && !w_rx_empty) || (r_tx_ie && !w_tx_full);

    assign w_status = {8'h00,
                       {(7 - DEPTH_LOG2){1'b0}}, r_rx_cnt,
                       {(7 - DEPTH_LOG2){1'b0}}, r_tx_cnt,
                       2'b00, r_udf, r_ovf,
                       w_rx_full, w_rx_empty, w_tx_empty, w_tx_full};

    // Read-data mux for the register map
    always_comb begin
        w_rd_data = 32'h0000_0000;
        case (w_off)
            OFF_DATA: begin
                if (w_rx_empty) begin
                    w_rd_data = 32'h0000_0000;
                end else begin
                    w_rd_data = r_rx_mem[r_rx_rptr];
                end
            end
            OFF_STATUS: w_rd_data = w_status;
            OFF_CTRL:   w_rd_data = {30'd0, r_tx_ie, r_rx_ie};
            default:    w_rd_data = 32'h0000_0000;
        endcase
    end

    // The bus is driven only during a selected load
    assign d_data = w_rd ? w_rd_data : {32{1'bz}};

    // TX storage write
    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr] <= d_data;
        end
    end

    // RX storage write
    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr] <= rx_data;
        end
    end

    // TX pointers and count; push and pop together leave the count unchanged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_wptr <= {PTR_W{1'b0}};
            r_tx_rptr <= {PTR_W{1'b0}};
            r_tx_cnt  <= ZERO_CNT;
        end else begin
            if (w_tx_push) begin
                r_tx_wptr <= r_tx_wptr + PTR_W'(1);
            end
            if (w_tx_pop) begin
                r_tx_rptr <= r_tx_rptr + PTR_W'(1);
            end
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                2'b01:   r_tx_cnt <= r_tx_cnt - CNT_W'(1);
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // RX pointers and count; push and pop together leave the count unchanged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_wptr <= {PTR_W{1'b0}};
            r_rx_rptr <= {PTR_W{1'b0}};
            r_rx_cnt  <= ZERO_CNT;
        end else begin
            if (w_rx_push) begin
                r_rx_wptr <= r_rx_wptr + PTR_W'(1);
            end
            if (w_rx_pop) begin
                r_rx_rptr <= r_rx_rptr + PTR_W'(1);
            end
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                2'b01:   r_rx_cnt <= r_rx_cnt - CNT_W'(1);
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    // Sticky error flags; a new event wins over a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_udf_evt) begin
                r_udf <= 1'b1;
            end else if (w_udf_clr) begin
                r_udf <= 1'b0;
            end
        end
    end

    // Interrupt enables
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_ie <= 1'b0;
            r_tx_ie <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_rx_ie <= d_data[0];
            r_tx_ie <= d_data[1];
        end
    end

endmodule

// File: tb/tb_bus_mailbox.sv
// Self-checking bench for bus_mailbox: a table of register accesses with
// hand-computed results, followed by directed sequences for FIFO fill/drain,
// simultaneous push/pop, the interrupt and asynchronous reset mid-access.
// The data bus has a pull-up so an undriven bus reads as all ones.
module tb_bus_mailbox;

    logic        clk;
    logic        reset_n;
    logic        strobe;
    logic        mem_rw;
    logic [31:0] d_addr;
    tri1  [31:0] d_data;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        rx_ready;
    logic        irq;

    logic        tb_drv;
    logic [31:0] tb_wdata;

    int n_checks = 0;
    int n_errors = 0;

    assign d_data = tb_drv ? tb_wdata : {32{1'bz}};

    bus_mailbox dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .strobe   (strobe),
        .mem_rw   (mem_rw),
        .d_addr   (d_addr),
        .d_data   (d_data),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        strobe   = 1'b1;
        mem_rw   = 1'b1;
        d_addr   = a;
        tb_drv   = 1'b1;
        tb_wdata = d;
        @(negedge clk);
        strobe   = 1'b0;
        tb_drv   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        strobe = 1'b1;
        mem_rw = 1'b0;
        d_addr = a;
        #2;
        d = d_data;
        @(negedge clk);
        strobe = 1'b0;
    endtask

    task automatic pop_tx();
        @(negedge clk);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    task automatic push_rx(input logic [31:0] d);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = d;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    logic [31:0] rd;

    initial begin
        // Register-map vectors starting from reset (BASE word address 0x100)
        vecs[0]  = '{1'b1, 32'h0000_0101, 32'h0, 32'h0000_0006};
        vecs[1]  = '{1'b1, 32'h0000_0102, 32'h0, 32'h0000_0000};
        vecs[2]  = '{1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_0101, 32'h0, 32'h0000_0104};
        vecs[4]  = '{1'b0, 32'h0000_0102, 32'hFFFF_FFFF, 32'h0};
        vecs[5]  = '{1'b1, 32'h0000_0102, 32'h0, 32'h0000_0003};
        vecs[6]  = '{1'b0, 32'h0000_0103, 32'h0000_1234, 32'h0};
        vecs[7]  = '{1'b1, 32'h0000_0103, 32'h0, 32'h0000_0000};
        vecs[8]  = '{1'b0, 32'h0000_0102, 32'h0000_0000, 32'h0};
        vecs[9]  = '{1'b1, 32'h0000_0102, 32'h0, 32'h0000_0000};
        vecs[10] = '{1'b1, 32'h0000_0100, 32'h0, 32'h0000_0000};
        vecs[11] = '{1'b1, 32'h0000_0101, 32'h0, 32'h0000_0124};
        vecs[12] = '{1'b0, 32'h0000_0101, 32'h0000_0020, 32'h0};
        vecs[13] = '{1'b1, 32'h0000_0101, 32'h0, 32'h0000_0104};
        vecs[14] = '{1'b0, 32'h0000_0104, 32'h0000_5555, 32'h0};
        vecs[15] = '{1'b1, 32'h0000_0101, 32'h0, 32'h0000_0104};

        reset_n  = 1'b0;
        strobe   = 1'b0;
        mem_rw   = 1'b0;
        d_addr   = 32'h0;
        tb_drv   = 1'b0;
        tb_wdata = 32'h0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 32'h0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        check("reset rx_ready", {31'd0, rx_ready}, 32'd1);
        check("reset tx_valid", {31'd0, tx_valid}, 32'd0);
        check("reset irq", {31'd0, irq}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].rd) begin
                bus_read(vecs[i].addr, rd);
                check($sformatf("vec %0d", i), rd, vecs[i].exp);
            end else begin
                bus_write(vecs[i].addr, vecs[i].wdata);
            end
        end

        // Single TX word seen by the consumer, then popped
        check("tx_valid one word", {31'd0, tx_valid}, 32'd1);
        check("tx_data one word", tx_data, 32'hDEAD_BEEF);
        pop_tx();
        check("tx_valid after pop", {31'd0, tx_valid}, 32'd0);
        bus_read(32'h0000_0101, rd);
        check("status after pop", rd, 32'h0000_0006);

        // Fill RX, offer a ninth word while full, drain in order, underflow
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = 32'hA000_0000 + i;
        end
        @(negedge clk);
        rx_data = 32'h0000_0BAD;
        @(negedge clk);
        rx_valid = 1'b0;
        check("rx_ready full", {31'd0, rx_ready}, 32'd0);
        bus_read(32'h0000_0101, rd);
        check("status rx full", rd, 32'h0008_000A);
        for (int i = 0; i < 8; i++) begin
            bus_read(32'h0000_0100, rd);
            check($sformatf("rx word %0d", i), rd, 32'hA000_0000 + i);
        end
        bus_read(32'h0000_0100, rd);
        check("rx underflow data", rd, 32'h0000_0000);
        bus_read(32'h0000_0101, rd);
        check("status udf", rd, 32'h0000_0026);
        bus_write(32'h0000_0101, 32'h0000_0030);
        bus_read(32'h0000_0101, rd);
        check("status udf cleared", rd, 32'h0000_0006);

        // Fill TX, overflow, clear ovf, drain and confirm the dropped word is gone
        for (int i = 0; i < 8; i++) begin
            bus_write(32'h0000_0100, 32'hC000_0000 + i);
        end
        bus_read(32'h0000_0101, rd);
        check("status tx full", rd, 32'h0000_0805);
        bus_write(32'h0000_0100, 32'h0000_0BAD);
        bus_read(32'h0000_0101, rd);
        check("status ovf", rd, 32'h0000_0815);
        bus_write(32'h0000_0101, 32'h0000_0010);
        bus_read(32'h0000_0101, rd);
        check("status ovf cleared", rd, 32'h0000_0805);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tx word %0d", i), tx_data, 32'hC000_0000 + i);
            pop_tx();
        end
        check("tx_valid drained", {31'd0, tx_valid}, 32'd0);

        // TX: core push and consumer pop in the same cycle
        bus_write(32'h0000_0100, 32'h1111_1111);
        @(negedge clk);
        strobe   = 1'b1;
        mem_rw   = 1'b1;
        d_addr   = 32'h0000_0100;
        tb_drv   = 1'b1;
        tb_wdata = 32'h2222_2222;
        tx_ready = 1'b1;
        @(negedge clk);
        strobe   = 1'b0;
        tb_drv   = 1'b0;
        tx_ready = 1'b0;
        check("tx simul data", tx_data, 32'h2222_2222);
        bus_read(32'h0000_0101, rd);
        check("tx simul status", rd, 32'h0000_0104);
        pop_tx();

        // RX: core pop and producer push in the same cycle
        push_rx(32'h3333_3333);
        @(negedge clk);
        strobe   = 1'b1;
        mem_rw   = 1'b0;
        d_addr   = 32'h0000_0100;
        rx_valid = 1'b1;
        rx_data  = 32'h4444_4444;
        #2;
        check("rx simul data", d_data, 32'h3333_3333);
        @(negedge clk);
        strobe   = 1'b0;
        rx_valid = 1'b0;
        bus_read(32'h0000_0101, rd);
        check("rx simul status", rd, 32'h0001_0002);
        bus_read(32'h0000_0100, rd);
        check("rx simul second", rd, 32'h4444_4444);

        // Interrupt from RX non-empty, then from TX not full
        bus_write(32'h0000_0102, 32'h0000_0001);
        check("irq idle", {31'd0, irq}, 32'd0);
        push_rx(32'h5555_5555);
        check("irq rx", {31'd0, irq}, 32'd1);
        bus_read(32'h0000_0100, rd);
        check("irq rx data", rd, 32'h5555_5555);
        check("irq cleared", {31'd0, irq}, 32'd0);
        bus_write(32'h0000_0102, 32'h0000_0002);
        check("irq tx", {31'd0, irq}, 32'd1);

        // Asynchronous reset in the middle of a TX burst
        bus_write(32'h0000_0102, 32'h0000_0003);
        bus_write(32'h0000_0100, 32'hE000_0000);
        bus_write(32'h0000_0100, 32'hE000_0001);
        @(negedge clk);
        strobe   = 1'b1;
        mem_rw   = 1'b1;
        d_addr   = 32'h0000_0100;
        tb_drv   = 1'b1;
        tb_wdata = 32'hE000_0002;
        #2;
        reset_n = 1'b0;
        #1;
        check("async tx_valid", {31'd0, tx_valid}, 32'd0);
        check("async irq", {31'd0, irq}, 32'd0);
        check("async rx_ready", {31'd0, rx_ready}, 32'd1);
        @(negedge clk);
        strobe = 1'b0;
        tb_drv = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(32'h0000_0101, rd);
        check("status after reset", rd, 32'h0000_0006);
        bus_read(32'h0000_0102, rd);
        check("ctrl after reset", rd, 32'h0000_0000);

        // Load outside the window leaves the bus undriven
        bus_read(32'h0000_0104, rd);
        check("outside window bus", rd, 32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
